alu6_issue: RTL

Issue/writeback stage that sits directly upstream of the team's combinational 6-bit ALU.
- Buffers incoming register-to-register instructions in a small FIFO.
- Reads operands from a 4-entry, 6-bit register file and drives the ALU's `a`/`b`/`c` inputs from registers.
- Captures the ALU result `F` one cycle later and writes it back.
- The ALU stays external; this block owns sequencing, storage and handshake.

---
 rtl/alu6_issue.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu6_issue.sv
// Issue/writeback stage feeding an external combinational 6-bit ALU: instruction FIFO,
// 4x6 register file, IDLE->EXEC->WB sequencer. Define ALU6_ISSUE_FLAGS_EN for wb_zf/wb_nf.
module alu6_issue #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_op,
  input  logic [1:0] in_rd,
  input  logic [1:0] in_ra,
  input  logic [1:0] in_rb,
  output logic [5:0] alu_a,
  output logic [5:0] alu_b,
  output logic [1:0] alu_c,
  input  logic [5:0] alu_f,
  output logic       wb_valid,
  output logic [1:0] wb_rd,
  output logic [5:0] wb_data,
  output logic       busy,
  input  logic [1:0] dbg_sel,
  output logic [5:0] dbg_data
`ifdef ALU6_ISSUE_FLAGS_EN
  ,
  output logic       wb_zf,
  output logic       wb_nf
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  instr_t        fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  instr_t        head;

  state_t        state;
  logic [1:0]    rd_q;
  logic [5:0]    rf [4];

  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && !empty;
  assign head     = fifo_mem[rd_ptr];
  assign busy     = !empty || (state != IDLE);
  assign dbg_data = rf[dbg_sel];

  // NOTE: FIFO payload storage has no reset; validity is tracked by count, so
  // stale contents are never observed and the array maps to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= instr_t'{in_op, in_rd, in_ra, in_rb};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the register file is reset (unlike the FIFO payload) because its
  // contents are architecturally visible: operands and dbg_data must read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_c    <= '0;
      rd_q     <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
`ifdef ALU6_ISSUE_FLAGS_EN
      wb_zf    <= 1'b0;
      wb_nf    <= 1'b0;
`endif
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_a <= rf[head.ra];
            alu_b <= rf[head.rb];
            alu_c <= head.op;
            rd_q  <= head.rd;
            state <= EXEC;
          end
        end
        EXEC: begin
          // ALU inputs have been stable for a full cycle; capture its result.
          wb_valid <= 1'b1;
          wb_rd    <= rd_q;
          wb_data  <= alu_f;
`ifdef ALU6_ISSUE_FLAGS_EN
          wb_zf    <= (alu_f == 6'd0);
          wb_nf    <= alu_f[5];
`endif
          state    <= WB;
        end
        WB: begin
          rf[rd_q] <= alu_f;
          wb_valid <= 1'b0;
`ifdef ALU6_ISSUE_FLAGS_EN
          wb_zf    <= 1'b0;
          wb_nf    <= 1'b0;
`endif
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
